// File: rtl/qk_score_if.sv
// Score stream from qk_score_engine to the row-wise softmax: one saturated score
// plus head/row/column tags per valid/ready handshake.
interface qk_score_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_HEADS  = 2,
    parameter int SEQ_LEN    = 8
);
    localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
    localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    logic                         score_valid;
    logic                         score_ready;
    logic signed [DATA_WIDTH-1:0] score_data;
    logic [HW-1:0]                score_head;
    logic [SW-1:0]                score_row;
    logic [SW-1:0]                score_col;
    logic                         score_last;

    modport master (
        output score_valid, score_data, score_head, score_row, score_col, score_last,
        input  score_ready
    );

    modport slave (
        input  score_valid, score_data, score_head, score_row, score_col, score_last,
        output score_ready
    );
endinterface

// File: rtl/qk_score_engine.sv
// Time-multiplexed multi-head QK^T score engine: one MAC per cycle, scaled and saturated scores
// streamed out. Define QK_CAUSAL_MASK_EN to skip j>i elements and emit the most negative score.
module qk_score_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int SEQ_LEN     = 8,
    parameter int HEAD_DIM    = 8,
    parameter int NUM_HEADS   = 2,
    parameter int SCALE_SHIFT = 0,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+$clog2(HEAD_DIM)+1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [DATA_WIDTH*NUM_HEADS*SEQ_LEN*HEAD_DIM-1:0] q_in,
    input  logic [DATA_WIDTH*NUM_HEADS*SEQ_LEN*HEAD_DIM-1:0] k_in,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           sat_flag,
    qk_score_if.master                                     sc
);
    localparam int HW    = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
    localparam int SW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int DI    = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
    localparam int MEM_W = DATA_WIDTH*NUM_HEADS*SEQ_LEN*HEAD_DIM;
    localparam int AW    = (MEM_W > 1) ? $clog2(MEM_W) : 1;
    localparam int SH    = FRAC_BITS + SCALE_SHIFT;

    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] NEG_FULL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] POS_FULL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, MAC, SCALE, OUT, DONE} state_t;

    function automatic logic sat_hit(input logic signed [ACC_WIDTH-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_score(input logic signed [ACC_WIDTH-1:0] v);
        if (v > MAX_V)      return POS_FULL;
        else if (v < MIN_V) return NEG_FULL;
        else                return v[DATA_WIDTH-1:0];
    endfunction

    state_t                        state_q, state_d;
    logic [MEM_W-1:0]              q_mem_q, q_mem_d, k_mem_q, k_mem_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [DI-1:0]                 d_q, d_d;
    logic [HW-1:0]                 h_q, h_d, head_q, head_d;
    logic [SW-1:0]                 i_q, i_d, j_q, j_d, row_q, row_d, col_q, col_d;
    logic                          busy_q, busy_d, done_q, done_d, sat_q, sat_d;
    logic                          valid_q, valid_d, last_q, last_d;
    logic signed [DATA_WIDTH-1:0]  data_q, data_d;

    logic [AW-1:0]                 q_base, k_base;
    logic signed [DATA_WIDTH-1:0]  q_el, k_el;
    logic signed [2*DATA_WIDTH-1:0] q_ext, k_ext, prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext, acc_shr;
    logic                          d_last, i_last, j_last, h_last;
    logic [SW-1:0]                 i_nxt, j_nxt;
    logic [HW-1:0]                 h_nxt;
    logic                          mask_cur, mask_nxt;

    always_comb begin
        q_base   = AW'(((int'(h_q)*SEQ_LEN + int'(i_q))*HEAD_DIM + int'(d_q))*DATA_WIDTH);
        k_base   = AW'(((int'(h_q)*SEQ_LEN + int'(j_q))*HEAD_DIM + int'(d_q))*DATA_WIDTH);
        q_el     = q_mem_q[q_base +: DATA_WIDTH];
        k_el     = k_mem_q[k_base +: DATA_WIDTH];
        q_ext    = {{DATA_WIDTH{q_el[DATA_WIDTH-1]}}, q_el};
        k_ext    = {{DATA_WIDTH{k_el[DATA_WIDTH-1]}}, k_el};
        prod     = q_ext * k_ext;
        prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        acc_shr  = acc_q >>> SH;
        d_last   = (d_q == DI'(HEAD_DIM-1));
        j_last   = (j_q == SW'(SEQ_LEN-1));
        i_last   = (i_q == SW'(SEQ_LEN-1));
        h_last   = (h_q == HW'(NUM_HEADS-1));
        // Column advances first, then row, then head.
        j_nxt    = j_last ? '0 : j_q + 1'b1;
        i_nxt    = j_last ? (i_last ? '0 : i_q + 1'b1) : i_q;
        h_nxt    = (j_last && i_last) ? h_q + 1'b1 : h_q;
    end

`ifdef QK_CAUSAL_MASK_EN
    assign mask_cur = (j_q > i_q);
    assign mask_nxt = (j_nxt > i_nxt);
`else
    assign mask_cur = 1'b0;
    assign mask_nxt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        q_mem_d = q_mem_q;
        k_mem_d = k_mem_q;
        acc_d   = acc_q;
        d_d     = d_q;
        h_d     = h_q;
        i_d     = i_q;
        j_d     = j_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sat_d   = sat_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        head_d  = head_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_mem_d = q_in;
                    k_mem_d = k_in;
                    acc_d   = '0;
                    d_d     = '0;
                    h_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    sat_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                if (d_last) state_d = SCALE;
                else        d_d     = d_q + 1'b1;
            end
            SCALE: begin
                if (mask_cur) begin
                    data_d = NEG_FULL;
                end else begin
                    data_d = sat_score(acc_shr);
                    if (sat_hit(acc_shr)) sat_d = 1'b1;
                end
                head_d  = h_q;
                row_d   = i_q;
                col_d   = j_q;
                last_d  = h_last && i_last && j_last;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (sc.score_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (h_last && i_last && j_last) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        h_d     = h_nxt;
                        i_d     = i_nxt;
                        j_d     = j_nxt;
                        acc_d   = '0;
                        d_d     = '0;
                        state_d = mask_nxt ? SCALE : MAC;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            h_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            head_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            h_q     <= h_d;
            i_q     <= i_d;
            j_q     <= j_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            head_q  <= head_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Operand memories and accumulator are always re-initialised on start.
    always_ff @(posedge clk) begin
        q_mem_q <= q_mem_d;
        k_mem_q <= k_mem_d;
        acc_q   <= acc_d;
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign sat_flag       = sat_q;
    assign sc.score_valid = valid_q;
    assign sc.score_data  = data_q;
    assign sc.score_head  = head_q;
    assign sc.score_row   = row_q;
    assign sc.score_col   = col_q;
    assign sc.score_last  = last_q;
endmodule

// File: tb/tb_qk_score_engine.sv
// Directed bench for qk_score_engine: a 1-head instance (SHIFT 0) and a 2-head instance (SHIFT 1),
// both SEQ_LEN=2, HEAD_DIM=2, Q8.8 data.
module tb_qk_score_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start_a, start_b, ready, sel;
    logic [63:0]  q_a, k_a;
    logic [127:0] q_b, k_b;
    logic         busy_a, done_a, sat_a, busy_b, done_b, sat_b;

    qk_score_if #(.DATA_WIDTH(16), .NUM_HEADS(1), .SEQ_LEN(2)) ifa ();
    qk_score_if #(.DATA_WIDTH(16), .NUM_HEADS(2), .SEQ_LEN(2)) ifb ();
    assign ifa.score_ready = ready;
    assign ifb.score_ready = ready;

    qk_score_engine #(.DATA_WIDTH(16), .FRAC_BITS(8), .SEQ_LEN(2), .HEAD_DIM(2),
                      .NUM_HEADS(1), .SCALE_SHIFT(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .q_in(q_a), .k_in(k_a),
        .busy(busy_a), .done(done_a), .sat_flag(sat_a), .sc(ifa.master));

    qk_score_engine #(.DATA_WIDTH(16), .FRAC_BITS(8), .SEQ_LEN(2), .HEAD_DIM(2),
                      .NUM_HEADS(2), .SCALE_SHIFT(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .q_in(q_b), .k_in(k_b),
        .busy(busy_b), .done(done_b), .sat_flag(sat_b), .sc(ifb.master));

`ifdef QK_CAUSAL_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic        o_valid, o_last, o_busy, o_done, o_sat, o_head, o_row, o_col;
    logic [15:0] o_data;
    assign o_valid = sel ? ifb.score_valid : ifa.score_valid;
    assign o_last  = sel ? ifb.score_last  : ifa.score_last;
    assign o_data  = sel ? ifb.score_data  : ifa.score_data;
    assign o_head  = sel ? ifb.score_head  : ifa.score_head;
    assign o_row   = sel ? ifb.score_row   : ifa.score_row;
    assign o_col   = sel ? ifb.score_col   : ifa.score_col;
    assign o_busy  = sel ? busy_b : busy_a;
    assign o_done  = sel ? done_b : done_a;
    assign o_sat   = sel ? sat_b  : sat_a;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] snap();
        return {o_busy, o_done, o_valid, o_last, o_sat, o_head, o_row, o_col, o_data};
    endfunction

    logic [15:0] hs_d   [16];
    logic [2:0]  hs_tag [16];
    logic        hs_last[16];
    int          hs_rel [16];
    int          n_hs, n_done, first_vld, done_rel, held;
    logic [23:0] snap_v;
    logic [15:0] exp_d  [8];

    task automatic run(input bit s, input logic [127:0] q, input logic [127:0] k,
                       input int bp, input int rst_at);
        sel = s;
        n_hs = 0; n_done = 0; first_vld = -1; done_rel = -1; held = 0;
        for (int n = 0; n < 16; n++) begin
            hs_d[n] = '0; hs_tag[n] = '0; hs_last[n] = 1'b0; hs_rel[n] = -1;
        end
        @(negedge clk);
        q_a = q[63:0]; k_a = k[63:0]; q_b = q; k_b = k;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        ready = 1'b1;
        for (int rel = 1; rel < 120; rel++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            if (rel == 2) begin
                q_a = '0; k_a = '0; q_b = '0; k_b = '0;
            end
            if (rel == 1) begin
                check("busy_start", o_busy, 1);
                check("sat_clear", o_sat, 0);
            end
            if (rst_at >= 0 && rel == rst_at + 1) begin
                check("rst_mid", snap(), 0);
                rst = 1'b0;
            end
            if (o_valid && first_vld < 0) begin
                first_vld = rel;
                snap_v = snap();
            end else if (o_valid && n_hs == 0 && first_vld >= 0) begin
                check("bp_stable", snap(), snap_v);
            end
            ready = !(o_valid && n_hs == 0 && held < bp);
            if (o_valid && !ready) held++;
            if (o_valid && ready && n_hs < 16) begin
                hs_d[n_hs] = o_data; hs_tag[n_hs] = {o_head, o_row, o_col};
                hs_last[n_hs] = o_last; hs_rel[n_hs] = rel; n_hs++;
            end
            if (o_done) begin
                n_done++;
                if (done_rel < 0) begin
                    done_rel = rel;
                    check("busy_at_done", o_busy, 0);
                end
            end
            if (rst_at >= 0 && rel == rst_at) rst = 1'b1;
            if (done_rel >= 0 && rel == done_rel + 2) break;
            if (rst_at >= 0 && rel == rst_at + 5) break;
        end
        ready = 1'b1;
    endtask

    task automatic verify(input int n_exp, input int bp, input logic exp_sat);
        int t;
        int i, j;
        logic [15:0] ex;
        check("n_elems", n_hs, n_exp);
        check("first_valid", first_vld, 4);
        t = 4 + bp;
        for (int n = 0; n < n_exp; n++) begin
            i = (n >> 1) & 1;
            j = n & 1;
            if (n > 0) t += (MASK && j > i) ? 2 : 4;
            ex = (MASK && j > i) ? 16'h8000 : exp_d[n];
            check("score", hs_d[n], ex);
            check("tags", hs_tag[n], n);
            check("last", hs_last[n], n == n_exp - 1);
            check("hs_cycle", hs_rel[n], t);
        end
        check("done_cycle", done_rel, t + 1);
        check("done_pulses", n_done, 1);
        check("sat_end", o_sat, exp_sat);
    endtask

    localparam logic [127:0] Q_V1  = {64'h0, 64'hFF00_0080_0200_0100};
    localparam logic [127:0] K_V1  = {64'h0, 64'h0100_0200_0100_0100};
    localparam logic [127:0] Q_S1  = {64'h0, 64'h0000_0000_7FFF_7FFF};
    localparam logic [127:0] Q_S2  = {64'h0, 64'h0000_0000_8000_8000};
    localparam logic [127:0] Q_B   = {64'h0100_0000_0000_0400, 64'hFF00_0080_0200_0100};
    localparam logic [127:0] K_B   = {64'h0200_FF00_0300_0100, 64'h0100_0200_0100_0100};

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1; sel = 1'b0;
        q_a = '0; k_a = '0; q_b = '0; k_b = '0;
        repeat (3) @(negedge clk);
        check("reset_state_a", snap(), 0);
        sel = 1'b1;
        #1 check("reset_state_b", snap(), 0);
        rst = 1'b0;

        exp_d = '{16'h0300, 16'h0400, 16'hFF80, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
        run(1'b0, Q_V1, K_V1, 0, -1);
        verify(4, 0, 1'b0);

        exp_d = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
        run(1'b0, Q_S1, Q_S1, 0, -1);
        verify(4, 0, 1'b1);

        exp_d = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
        run(1'b0, Q_S2, Q_S1, 0, -1);
        verify(4, 0, 1'b1);

        exp_d = '{16'h0300, 16'h0400, 16'hFF80, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
        run(1'b0, Q_V1, K_V1, 5, -1);
        verify(4, 5, 1'b0);

        run(1'b0, Q_V1, K_V1, 10, 6);
        check("rst_no_elems", n_hs, 0);
        check("rst_no_done", n_done, 0);

        run(1'b0, Q_V1, K_V1, 0, -1);
        verify(4, 0, 1'b0);

        exp_d = '{16'h0180, 16'h0200, 16'hFFC0, 16'h0000, 16'h0200, 16'hFE00, 16'h0180, 16'h0100};
        run(1'b1, Q_B, K_B, 0, -1);
        verify(8, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
